// File: rtl/dm_subword_if.sv
// dm_subword request/response bundle.
// master = MEM stage driver, slave = the data memory.
interface dm_subword_if;
   logic [31:0] pc;
   logic [31:0] addr;
   logic        we;
   logic        re;
   logic [1:0]  size;
   logic        sext;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        rvalid;
   logic        busy;
   logic        misalign;
   logic [31:0] bad_addr;
   logic [31:0] bad_pc;

   modport master (
      output pc, addr, we, re, size, sext, wdata,
      input  rdata, rvalid, busy, misalign, bad_addr, bad_pc
   );

   modport slave (
      input  pc, addr, we, re, size, sext, wdata,
      output rdata, rvalid, busy, misalign, bad_addr, bad_pc
   );
endinterface

// File: rtl/dm_subword.sv
// Sub-word data memory for the MEM stage.
// Byte/half/word access, registered load port, post-reset clear sweep.
module dm_subword #(
   parameter int DEPTH_LOG2     = 10,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input logic        clk,
   input logic        reset,
   dm_subword_if.slave bus
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   typedef enum logic {CLEAR, READY} state_t;

   state_t                state;
   logic [DEPTH_LOG2-1:0] ptr;
   logic [31:0]           mem [DEPTH];

   logic [31:0] rdataQ;
   logic        rvalidQ;
   logic        misalignQ;
   logic [31:0] badAddrQ;
   logic [31:0] badPcQ;

   logic [DEPTH_LOG2-1:0] wordIdx;
   logic [DEPTH_LOG2-1:0] wIdx;
   logic [1:0]            off;
   logic                  isByte;
   logic                  isHalf;
   logic                  isWord;
   logic                  misaligned;
   logic                  active;
   logic                  doStore;
   logic                  doLoad;
   logic                  fault;
   logic [3:0]            laneMask;
   logic [31:0]           laneData;
   logic [31:0]           rword;
   logic [31:0]           byteSel;
   logic [15:0]           halfSel;
   logic [31:0]           loadVal;
   logic                  unusedBits;

   // Address bits above the array alias; they are deliberately dropped.
   assign unusedBits = ^{bus.addr[31:DEPTH_LOG2+2]};

   // Decode the request and classify it as store, load or fault.
   always_comb begin
      wordIdx    = bus.addr[DEPTH_LOG2+1:2];
      off        = bus.addr[1:0];
      isByte     = (bus.size == 2'b00);
      isHalf     = (bus.size == 2'b01);
      isWord     = bus.size[1];
      misaligned = (isHalf && off[0]) || (isWord && (off != 2'b00));
      active     = (state == READY);
      fault      = active && (bus.we || bus.re) && misaligned;
      doStore    = active && bus.we && !misaligned;
      doLoad     = active && bus.re && !bus.we && !misaligned;
   end

   // Steer write lanes: clear sweep owns the port while busy.
   always_comb begin
      laneMask = 4'b0000;
      laneData = 32'h0;
      wIdx     = wordIdx;
      if (state == CLEAR) begin
         laneMask = 4'b1111;
         laneData = 32'h0;
         wIdx     = ptr;
      end else if (doStore) begin
         unique case (1'b1)
            isByte: begin
               laneMask = 4'b0001 << off;
               laneData = {4{bus.wdata[7:0]}};
            end
            isHalf: begin
               laneMask = off[1] ? 4'b1100 : 4'b0011;
               laneData = {2{bus.wdata[15:0]}};
            end
            isWord: begin
               laneMask = 4'b1111;
               laneData = bus.wdata;
            end
         endcase
      end
   end

   // Byte-enabled array write; unselected lanes keep their contents.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (laneMask[i]) mem[wIdx][8*i +: 8] <= laneData[8*i +: 8];
      end
   end

   // Select and extend the load result from the addressed word.
   always_comb begin
      rword   = mem[wordIdx];
      byteSel = rword >> {off, 3'b000};
      halfSel = off[1] ? rword[31:16] : rword[15:0];
      loadVal = rword;
      unique case (1'b1)
         isByte: loadVal = {{24{bus.sext & byteSel[7]}}, byteSel[7:0]};
         isHalf: loadVal = {{16{bus.sext & halfSel[15]}}, halfSel};
         isWord: loadVal = rword;
      endcase
   end

   // Sequencer plus registered load/fault outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= CLEAR_ON_RESET ? CLEAR : READY;
         ptr       <= '0;
         rdataQ    <= 32'h0;
         rvalidQ   <= 1'b0;
         misalignQ <= 1'b0;
         badAddrQ  <= 32'h0;
         badPcQ    <= 32'h0;
      end else begin
         rvalidQ   <= doLoad;
         misalignQ <= fault;
         if (doLoad) rdataQ <= loadVal;
         if (fault) begin
            badAddrQ <= bus.addr;
            badPcQ   <= bus.pc;
         end
         unique case (state)
            CLEAR: begin
               ptr <= ptr + 1'b1;
               if (ptr == '1) state <= READY;
            end
            READY: ;
         endcase
      end
   end

   assign bus.rdata    = rdataQ;
   assign bus.rvalid   = rvalidQ;
   assign bus.busy     = (state == CLEAR);
   assign bus.misalign = misalignQ;
   assign bus.bad_addr = badAddrQ;
   assign bus.bad_pc   = badPcQ;

endmodule

// File: tb/tb_dm_subword.sv
// Randomised bench for dm_subword against a byte-array model.
// Directed scenarios first, then random traffic and reset cases.
module tb_dm_subword;

   localparam int DL     = 4;
   localparam int NBYTES = 4 << DL;

   logic clk = 1'b0;
   logic reset = 1'b0;

   dm_subword_if bus();

   dm_subword #(
      .DEPTH_LOG2(DL),
      .CLEAR_ON_RESET(1'b1)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int nCmp = 0;
   int nErr = 0;

   logic [7:0]  mb [NBYTES];
   logic [31:0] expRdata = 32'h0;
   logic [31:0] expBA = 32'h0;
   logic [31:0] expBP = 32'h0;
   logic        expRv = 1'b0;
   logic        expMis = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      nCmp++;
      if (got !== exp) begin
         nErr++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   function automatic bit mMis(input logic [1:0] sz, input logic [31:0] a);
      int o;
      o = int'(a % 4);
      if (sz == 2'd1) return (o % 2) != 0;
      if (sz >= 2'd2) return o != 0;
      return 1'b0;
   endfunction

   function automatic int mBytes(input logic [1:0] sz);
      if (sz == 2'd0) return 1;
      if (sz == 2'd1) return 2;
      return 4;
   endfunction

   function automatic logic [31:0] mLoad(input logic [1:0] sz, input logic sx,
                                         input logic [31:0] a);
      int n;
      int b;
      logic [31:0] v;
      n = mBytes(sz);
      b = int'(a % NBYTES);
      b = b - (b % n);
      v = 32'h0;
      for (int k = 0; k < n; k++) v = v + (32'(mb[b+k]) << (8*k));
      if (sx && n == 1 && v >= 32'd128) v = v + 32'hFFFF_FF00;
      if (sx && n == 2 && v >= 32'd32768) v = v + 32'hFFFF_0000;
      return v;
   endfunction

   task automatic mStore(input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd);
      int n;
      int b;
      n = mBytes(sz);
      b = int'(a % NBYTES);
      b = b - (b % n);
      for (int k = 0; k < n; k++) mb[b+k] = 8'(wd >> (8*k));
   endtask

   task automatic op(input logic w, input logic r, input logic [1:0] sz,
                     input logic sx, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] p);
      bus.we = w;
      bus.re = r;
      bus.size = sz;
      bus.sext = sx;
      bus.addr = a;
      bus.wdata = wd;
      bus.pc = p;
      expRv = 1'b0;
      expMis = 1'b0;
      if (w || r) begin
         if (mMis(sz, a)) begin
            expMis = 1'b1;
            expBA = a;
            expBP = p;
         end else if (w) begin
            mStore(sz, a, wd);
         end else begin
            expRdata = mLoad(sz, sx, a);
            expRv = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      chk("rvalid", 32'(bus.rvalid), 32'(expRv));
      chk("rdata", bus.rdata, expRdata);
      chk("misalign", 32'(bus.misalign), 32'(expMis));
      chk("bad_addr", bus.bad_addr, expBA);
      chk("bad_pc", bus.bad_pc, expBP);
      bus.we = 1'b0;
      bus.re = 1'b0;
   endtask

   task automatic assertReset();
      reset = 1'b0;
      bus.we = 1'b0;
      bus.re = 1'b0;
      #1;
      chk("rst_rdata", bus.rdata, 32'h0);
      chk("rst_rvalid", 32'(bus.rvalid), 32'h0);
      chk("rst_misalign", 32'(bus.misalign), 32'h0);
      chk("rst_bad_addr", bus.bad_addr, 32'h0);
      chk("rst_bad_pc", bus.bad_pc, 32'h0);
      chk("rst_busy", 32'(bus.busy), 32'h1);
      expRdata = 32'h0;
      expBA = 32'h0;
      expBP = 32'h0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic releaseSweep(input logic probe);
      int n;
      n = 0;
      reset = 1'b1;
      bus.we = 1'b0;
      bus.re = probe;
      bus.size = 2'd2;
      bus.addr = 32'h0;
      while (bus.busy === 1'b1 && n < 40) begin
         n++;
         @(posedge clk);
         #1;
         chk("busy_rvalid", 32'(bus.rvalid), 32'h0);
      end
      bus.re = 1'b0;
      chk("sweep_len", 32'(n), 32'd16);
      for (int i = 0; i < NBYTES; i++) mb[i] = 8'h0;
   endtask

   task automatic randOp();
      logic w;
      logic r;
      w = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      op(w, r, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
         32'($urandom_range(0, 255)), $urandom, $urandom);
   endtask

   initial begin
      bus.pc = 32'h0;
      bus.addr = 32'h0;
      bus.we = 1'b0;
      bus.re = 1'b0;
      bus.size = 2'd0;
      bus.sext = 1'b0;
      bus.wdata = 32'h0;
      for (int i = 0; i < NBYTES; i++) mb[i] = 8'h0;

      assertReset();
      releaseSweep(1'b1);
      op(0, 1, 2'd2, 0, 32'h3C, 32'h0, 32'h100);
      chk("lw3c_zero", bus.rdata, 32'h0);

      op(1, 0, 2'd2, 0, 32'h8, 32'h1122_3344, 32'h104);
      op(1, 0, 2'd0, 0, 32'h9, 32'h0000_00AA, 32'h108);
      op(1, 0, 2'd1, 0, 32'hA, 32'h0000_BEEF, 32'h10C);
      op(0, 1, 2'd2, 0, 32'h8, 32'h0, 32'h110);
      chk("lw8", bus.rdata, 32'hBEEF_AA44);
      op(0, 1, 2'd0, 1, 32'h9, 32'h0, 32'h114);
      chk("lb9", bus.rdata, 32'hFFFF_FFAA);
      op(0, 1, 2'd0, 0, 32'h9, 32'h0, 32'h118);
      chk("lbu9", bus.rdata, 32'h0000_00AA);
      op(0, 1, 2'd1, 1, 32'hA, 32'h0, 32'h11C);
      chk("lhA", bus.rdata, 32'hFFFF_BEEF);

      op(1, 0, 2'd2, 0, 32'h4, 32'h5555_6666, 32'h120);
      op(1, 0, 2'd2, 0, 32'h6, 32'h1234_5678, 32'h3000);
      chk("mis_pulse", 32'(bus.misalign), 32'h1);
      chk("mis_addr", bus.bad_addr, 32'h6);
      chk("mis_pc", bus.bad_pc, 32'h3000);
      op(0, 1, 2'd2, 0, 32'h4, 32'h0, 32'h124);
      chk("mis_once", 32'(bus.misalign), 32'h0);
      chk("mis_nowr", bus.rdata, 32'h5555_6666);

      op(1, 1, 2'd2, 0, 32'h40, 32'hCAFE_F00D, 32'h128);
      chk("alias_norv", 32'(bus.rvalid), 32'h0);
      op(0, 1, 2'd2, 0, 32'h0, 32'h0, 32'h12C);
      chk("alias_lw0", bus.rdata, 32'hCAFE_F00D);

      op(0, 1, 2'd2, 0, 32'h0, 32'h0, 32'h130);
      op(0, 1, 2'd2, 0, 32'h8, 32'h0, 32'h134);
      op(0, 1, 2'd2, 0, 32'hC, 32'h0, 32'h138);
      op(0, 0, 2'd2, 0, 32'h0, 32'h0, 32'h13C);

      repeat (400) randOp();

      assertReset();
      releaseSweep(1'b0);
      repeat (60) randOp();

      assertReset();
      reset = 1'b1;
      repeat (7) begin
         @(posedge clk);
         #1;
      end
      chk("mid_busy", 32'(bus.busy), 32'h1);
      assertReset();
      releaseSweep(1'b0);
      for (int i = 0; i < 16; i++)
         op(0, 1, 2'd2, 0, 32'(4*i), 32'h0, 32'h200);
      repeat (100) randOp();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/dm_subword.md
# dm_subword

Parametrised successor to the single-cycle word data memory. It provides byte, halfword and word loads and stores, sign or zero extension, and a registered read port. A post-reset clear sequencer zeroes the array one word per cycle. Alignment faults are flagged rather than corrupting memory. It sits in the MEM stage, between the ALU address output and the write-back mux.

## Interface
- DEPTH_LOG2, default 10: number of word-address bits. Depth is 2^DEPTH_LOG2 words of 32 bits (default 4 KB).
- CLEAR_ON_RESET, default 1: 1 runs the clear sweep after reset; 0 skips it (array contents undefined, ready immediately).

Ports:
- clk  in  1  system clock; everything is on the rising edge.
- reset  in  1  reset, asynchronous, active-low (0 = in reset).
- pc  in  32  PC of the instruction issuing the access; captured on fault.
- addr  in  32  byte address. Bits [DEPTH_LOG2+1:2] select the word; higher bits are ignored, so addresses alias (wrap).
- we  in  1  store request.
- re  in  1  load request.
- size  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
- sext  in  1  1 = sign-extend sub-word loads; 0 = zero-extend.
- wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rdata  out  32  load result, registered.
- rvalid  out  1  one-cycle pulse; rdata is new this cycle.
- busy  out  1  clear sweep in progress; requests are ignored.
- misalign  out  1  one-cycle pulse on an alignment fault.
- bad_addr  out  32  addr of the last faulting access.
- bad_pc  out  32  pc of the last faulting access.

## Operation
State machine: CLEAR, READY.
- Reset asserted: state CLEAR (READY if CLEAR_ON_RESET=0). Sweep pointer = 0. All outputs are 0, except busy = 1 in CLEAR.
- CLEAR: each cycle, write 0 to word[ptr] and increment ptr. After writing word 2^DEPTH_LOG2-1, go to READY; busy drops on that transition. we and re are ignored with no side effects.
- Reset asserted mid-sweep: the sweep restarts at 0.
- READY, request accepted when we or re is 1.
- we and re both 1: treated as a store only. No rvalid.
- Alignment fault: half with addr[0]=1, or word with addr[1:0]≠00.
  - No array write and no rvalid; rdata is unchanged.
  - misalign pulses; bad_addr and bad_pc are loaded.
- Store lanes:
  - byte: lane addr[1:0] gets wdata[7:0].
  - half: lanes {addr[1],1} and {addr[1],0} get wdata[15:0].
  - word: all four lanes.
  - Unselected lanes are preserved.
- Load: select byte at addr[1:0], or half at addr[1], or the full word. Extend to 32 bits per sext. sext is ignored for word loads.
- Lane order is little-endian: byte 0 = bits [7:0].

## Timing
- Store: the array updates at the accepting edge.
- Load: latency 1. Request at edge N gives rdata and rvalid=1 after edge N+1's… precisely: both become visible in the cycle following edge N, and rvalid returns to 0 after one cycle unless another load is accepted.
- Back-to-back loads: one result per cycle.
- Load the cycle after a store to the same word: returns the new data. There is no same-cycle read-during-write case, since store has priority.
- Clear sweep: exactly 2^DEPTH_LOG2 cycles after reset deasserts. busy is 0 in the cycle after the last clear write.
- misalign: asserted in the cycle after the faulting request edge, for one cycle. bad_addr and bad_pc are updated at that same edge and hold until the next fault.
- rdata holds its value between loads. It resets to 0 only on reset.

## Test plan
- Reset then sweep (DEPTH_LOG2=4): release reset. busy must stay 1 for exactly 16 cycles; a word load at 0x0 issued during busy gives no rvalid. After the sweep, a load of 0x3C returns 0x00000000.
- Sub-word store/load:
  - sw 0x11223344 @0x8; sb 0xAA @0x9; sh 0xBEEF @0xA.
  - lw @0x8 must return 0xBEEFAA44.
  - lb sext @0x9 must return 0xFFFFFFAA; lbu @0x9 must return 0x000000AA.
  - lh sext @0xA must return 0xFFFFBEEF.
- Misalign: sw 0x12345678 @0x6 with pc=0x3000. Required: misalign=1 for one cycle, bad_addr=0x6, bad_pc=0x3000, and lw @0x4 still reads its old value.
- Aliasing and priority (DEPTH_LOG2=4): sw 0xCAFEF00D @0x40, which aliases 0x0, with re=1 in the same cycle. Required: no rvalid; a following lw @0x0 returns 0xCAFEF00D.
- Back-to-back loads @0x0, @0x8, @0xC on consecutive cycles: rvalid high for 3 cycles with the correct data in order.
- Reset pulsed at sweep pointer 7: the sweep restarts and busy lasts the full 16 cycles after the new release.
